// File: rtl/tag_checker.sv
// Tag checker: pairs each popped tag FIFO entry with its metadata R burst,
// compares the stored tag and presents one registered hit/miss result per request.
module tag_checker #(
    parameter int ADDR_WIDTH   = 64,
    parameter int ID_WIDTH     = 4,
    parameter int TID_WIDTH    = 16,
    parameter int INDEX_WIDTH  = 22,
    parameter int OFFSET_WIDTH = 6,
    parameter int DATA_WIDTH   = 512,
    parameter int CNT_WIDTH    = 32,
    parameter int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              tag_fifo_empty_i,
    output logic                              tag_fifo_rden_o,
    input  logic [ADDR_WIDTH+TID_WIDTH:0]     tag_fifo_data_i,
    input  logic [ID_WIDTH-1:0]               rid_i,
    input  logic [DATA_WIDTH-1:0]             rdata_i,
    input  logic [1:0]                        rresp_i,
    input  logic                              rlast_i,
    input  logic                              rvalid_i,
    output logic                              rready_o,
    output logic                              res_valid_o,
    input  logic                              res_ready_i,
    output logic                              res_hit_o,
    output logic                              res_dirty_o,
    output logic                              res_write_o,
    output logic                              res_err_o,
    output logic [TID_WIDTH-1:0]              res_tid_o,
    output logic [ADDR_WIDTH-1:0]             res_addr_o,
    output logic [TAG_WIDTH-1:0]              res_victim_tag_o,
    output logic [CNT_WIDTH-1:0]              hit_cnt_o,
    output logic [CNT_WIDTH-1:0]              miss_cnt_o,
    output logic [1:0]                        dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_CMP   = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic                  req_write_q;
    logic [TID_WIDTH-1:0]  req_tid_q;
    logic [ADDR_WIDTH-1:0] req_addr_q;
    logic [TAG_WIDTH-1:0]  meta_tag_q;
    logic                  meta_valid_q;
    logic                  meta_dirty_q;
    logic                  err_q;

    logic accept_first;
    logic res_fire;
    logic cmp_hit;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; a producer holds valid and payload stable until that edge.
    assign accept_first = (state_q == S_IDLE) && rvalid_i && !tag_fifo_empty_i;
    assign res_fire     = (state_q == S_OUT) && res_ready_i;
    assign cmp_hit      = meta_valid_q && !err_q &&
                          (meta_tag_q == req_addr_q[ADDR_WIDTH-1 -: TAG_WIDTH]);
    assign dbg_state_o  = state_q;

    logic unused_ok;
    assign unused_ok = ^{rid_i, rdata_i[DATA_WIDTH-1:TAG_WIDTH+2]};

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d         = state_q;
        rready_o        = 1'b0;
        tag_fifo_rden_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A beat with no matching FIFO entry is left stalled, never consumed.
                if (accept_first) begin
                    rready_o        = 1'b1;
                    tag_fifo_rden_o = 1'b1;
                    state_d         = rlast_i ? S_CMP : S_DRAIN;
                end
            end
            S_DRAIN: begin
                rready_o = 1'b1;
                if (rvalid_i && rlast_i) state_d = S_CMP;
            end
            S_CMP: state_d = S_OUT;
            S_OUT: if (res_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_write_q  <= 1'b0;
            req_tid_q    <= '0;
            req_addr_q   <= '0;
            meta_tag_q   <= '0;
            meta_valid_q <= 1'b0;
            meta_dirty_q <= 1'b0;
            err_q        <= 1'b0;
        end else if (accept_first) begin
            req_write_q  <= tag_fifo_data_i[ADDR_WIDTH+TID_WIDTH];
            req_tid_q    <= tag_fifo_data_i[ADDR_WIDTH +: TID_WIDTH];
            req_addr_q   <= tag_fifo_data_i[ADDR_WIDTH-1:0];
            meta_tag_q   <= rdata_i[TAG_WIDTH-1:0];
            meta_valid_q <= rdata_i[TAG_WIDTH];
            meta_dirty_q <= rdata_i[TAG_WIDTH+1];
            err_q        <= (rresp_i != 2'b00);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_valid_o      <= 1'b0;
            res_hit_o        <= 1'b0;
            res_dirty_o      <= 1'b0;
            res_write_o      <= 1'b0;
            res_err_o        <= 1'b0;
            res_tid_o        <= '0;
            res_addr_o       <= '0;
            res_victim_tag_o <= '0;
        end else if (state_q == S_CMP) begin
            res_valid_o      <= 1'b1;
            res_hit_o        <= cmp_hit;
            res_dirty_o      <= meta_dirty_q;
            res_write_o      <= req_write_q;
            res_err_o        <= err_q;
            res_tid_o        <= req_tid_q;
            res_addr_o       <= req_addr_q;
            res_victim_tag_o <= meta_tag_q;
        end else if (res_fire) begin
            res_valid_o <= 1'b0;
        end
    end

    // Statistics count accepted results only and stick at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else if (res_fire) begin
            if (res_hit_o) begin
                if (!(&hit_cnt_o)) hit_cnt_o <= hit_cnt_o + 1'b1;
            end else begin
                if (!(&miss_cnt_o)) miss_cnt_o <= miss_cnt_o + 1'b1;
            end
        end
    end

endmodule
